// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : divider_pkg
// Purpose  : RV32M divide operation codes and shared divider helpers.
// Revision : 1.0 - initial release
// ============================================================================
package divider_pkg;

    localparam logic [4:0] ALU_DIV  = 5'h0c;
    localparam logic [4:0] ALU_DIVU = 5'h0d;
    localparam logic [4:0] ALU_REM  = 5'h0e;
    localparam logic [4:0] ALU_REMU = 5'h0f;

    function automatic logic [31:0] cond_negate(input logic [31:0] value, input logic neg);
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One radix-2 restoring division iteration (combinational).
// Revision : 1.0 - initial release
// ============================================================================
module div_step (
    input  logic [31:0] rem_in,
    input  logic        dvd_bit,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic        q_bit
);

    logic [32:0] w_diff;
    logic        w_borrow;

    assign w_diff   = {rem_in, dvd_bit} - {1'b0, divisor};
    // A set rem_in[31] puts the shifted value above any 32-bit divisor.
    assign w_borrow = ~rem_in[31] & w_diff[32];
    assign q_bit    = ~w_borrow;
    assign rem_out  = w_borrow ? {rem_in[30:0], dvd_bit} : w_diff[31:0];

endmodule
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module   : divider
// Purpose  : Iterative 32-bit DIV/DIVU/REM/REMU unit, start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module divider
    import divider_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic [4:0]  ID_EX_alu_func,
    output logic        busy,
    output logic        done,
    output logic [31:0] div_result
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_fix  = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_dvd;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_sel_rem;
    logic [31:0] r_result;

    logic        w_signed;
    logic        w_sel_rem;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_div_zero;
    logic        w_ovf;
    logic [31:0] w_special_res;
    logic [31:0] w_step_rem;
    logic        w_q_bit;
    logic [31:0] w_fix_res;

    // Unknown function codes fall through to unsigned quotient.
    assign w_signed   = (ID_EX_alu_func == ALU_DIV) || (ID_EX_alu_func == ALU_REM);
    assign w_sel_rem  = (ID_EX_alu_func == ALU_REM) || (ID_EX_alu_func == ALU_REMU);
    assign w_a_neg    = w_signed & opa[31];
    assign w_b_neg    = w_signed & opb[31];
    assign w_div_zero = (opb == 32'd0);
    assign w_ovf      = w_signed && (opa == 32'h8000_0000) && (opb == 32'hffff_ffff);

    assign w_special_res = w_div_zero ? (w_sel_rem ? opa   : 32'hffff_ffff)
                                      : (w_sel_rem ? 32'd0 : 32'h8000_0000);

    div_step u_div_step (
        .rem_in  (r_rem),
        .dvd_bit (r_dvd[31]),
        .divisor (r_dvs),
        .rem_out (w_step_rem),
        .q_bit   (w_q_bit)
    );

    assign w_fix_res = r_sel_rem ? cond_negate(r_rem, r_neg_r) : cond_negate(r_dvd, r_neg_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_idle;
            r_cnt     <= 5'd0;
            r_dvd     <= 32'd0;
            r_rem     <= 32'd0;
            r_dvs     <= 32'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_sel_rem <= 1'b0;
            r_result  <= 32'd0;
        end else if (flush) begin
            r_state <= c_idle;
            r_cnt   <= 5'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_sel_rem <= w_sel_rem;
                        r_cnt     <= 5'd0;
                        if (w_div_zero || w_ovf) begin
                            r_result <= w_special_res;
                            r_state  <= c_done;
                        end else begin
                            r_dvd   <= cond_negate(opa, w_a_neg);
                            r_dvs   <= cond_negate(opb, w_b_neg);
                            r_rem   <= 32'd0;
                            r_state <= c_calc;
                        end
                    end
                end
                c_calc: begin
                    r_rem <= w_step_rem;
                    r_dvd <= {r_dvd[30:0], w_q_bit};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= c_fix;
                    end
                end
                c_fix: begin
                    r_result <= w_fix_res;
                    r_state  <= c_done;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign busy       = (r_state != c_idle);
    assign done       = (r_state == c_done);
    assign div_result = r_result;

endmodule
`default_nettype wire
